// File: rtl/alu_pkg.sv
// alu_pkg: ALU operation codes, RV32I opcodes and issue-controller encodings shared with the ALU.
package alu_pkg;
    localparam logic [5:0] ALU_IDLE = 6'd0;
    localparam logic [5:0] ALU_ADD  = 6'd1;
    localparam logic [5:0] ALU_SUB  = 6'd2;
    localparam logic [5:0] ALU_SLL  = 6'd3;
    localparam logic [5:0] ALU_SLT  = 6'd4;
    localparam logic [5:0] ALU_XOR  = 6'd6;
    localparam logic [5:0] ALU_SRL  = 6'd7;
    localparam logic [5:0] ALU_SRA  = 6'd8;
    localparam logic [5:0] ALU_OR   = 6'd9;
    localparam logic [5:0] ALU_AND  = 6'd10;
    localparam logic [5:0] ALU_ADDI = 6'd11;
    localparam logic [5:0] ALU_SLLI = 6'd12;
    localparam logic [5:0] ALU_SLTI = 6'd13;
    localparam logic [5:0] ALU_XORI = 6'd15;
    localparam logic [5:0] ALU_SRLI = 6'd16;
    localparam logic [5:0] ALU_ORI  = 6'd17;
    localparam logic [5:0] ALU_ANDI = 6'd18;
    localparam logic [5:0] ALU_BEQ  = 6'd27;
    localparam logic [5:0] ALU_BNE  = 6'd28;
    localparam logic [5:0] ALU_BGE  = 6'd31;
    localparam logic [5:0] ALU_BLT  = 6'd32;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXECUTE, S_WB} state_t;
    typedef enum logic [1:0] {IMM_ZERO, IMM_SEXT, IMM_ZEXT, IMM_RS1} imm_sel_t;
endpackage

// File: rtl/alu_decode.sv
// alu_decode: maps an RV32I instruction's opcode/funct fields to an ALU code, class and immediate select.
module alu_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [5:0] code,
    output logic       is_br,
    output logic       illegal,
    output imm_sel_t   imm_sel
);
    always_comb begin
        code    = ALU_IDLE;
        is_br   = 1'b0;
        imm_sel = IMM_ZERO;
        case (opcode)
            OP_R: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'd0:    code = ALU_ADD;
                        3'd1:    code = ALU_SLL;
                        3'd2:    code = ALU_SLT;
                        3'd4:    code = ALU_XOR;
                        3'd5:    code = ALU_SRL;
                        3'd6:    code = ALU_OR;
                        3'd7:    code = ALU_AND;
                        default: code = ALU_IDLE;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    code = funct3 == 3'd0 ? ALU_SUB : funct3 == 3'd5 ? ALU_SRA : ALU_IDLE;
                end
            end
            OP_I: begin
                imm_sel = IMM_SEXT;
                case (funct3)
                    3'd0:    code = ALU_ADDI;
                    3'd2:    code = ALU_SLTI;
                    3'd4:    code = ALU_XORI;
                    3'd6:    code = ALU_ORI;
                    3'd7:    code = ALU_ANDI;
                    3'd1: begin
                        code    = funct7 == 7'b0 ? ALU_SLLI : ALU_IDLE;
                        imm_sel = IMM_RS1;
                    end
                    3'd5: begin
                        code    = funct7 == 7'b0 ? ALU_SRLI : ALU_IDLE;
                        imm_sel = IMM_ZEXT;
                    end
                    default: code = ALU_IDLE;
                endcase
            end
            OP_BR: begin
                is_br = 1'b1;
                case (funct3)
                    3'd0:    code = ALU_BEQ;
                    3'd1:    code = ALU_BNE;
                    3'd4:    code = ALU_BLT;
                    3'd5:    code = ALU_BGE;
                    default: code = ALU_IDLE;
                endcase
            end
            default: code = ALU_IDLE;
        endcase
    end

    assign illegal = code == ALU_IDLE;
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: four-state issue FSM that feeds the ALU one instruction at a time
// and turns its result into a register write-back or a branch decision.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RF_AW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    output logic [RF_AW-1:0] rs1_addr,
    output logic [RF_AW-1:0] rs2_addr,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    output logic [5:0]       alu_control,
    output logic [XLEN-1:0]  src1,
    output logic [XLEN-1:0]  src2,
    output logic [XLEN-1:0]  imm_val_r,
    output logic [3:0]       shamt,
    input  logic [XLEN-1:0]  alu_result,
    output logic             rd_we,
    output logic [RF_AW-1:0] rd_addr,
    output logic [XLEN-1:0]  rd_wdata,
    output logic             br_valid,
    output logic             br_taken,
    output logic             illegal
);
    state_t     state;
    logic [5:0] code_q;
    logic       br_q;
    imm_sel_t   imm_sel_q;
    logic [11:0] imm_q;
    logic [RF_AW-1:0] rd_q;
    logic [5:0] dec_code;
    logic       dec_br;
    logic       dec_illegal;
    imm_sel_t   dec_imm_sel;

    alu_decode u_decode (
        .opcode  (instr[6:0]),
        .funct3  (instr[14:12]),
        .funct7  (instr[31:25]),
        .code    (dec_code),
        .is_br   (dec_br),
        .illegal (dec_illegal),
        .imm_sel (dec_imm_sel)
    );

    // bge is issued with swapped operands: the ALU tests src2 >= src1
    wire swap = code_q == ALU_BGE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            instr_ready <= 1'b1;
            code_q      <= '0;
            br_q        <= 1'b0;
            imm_sel_q   <= IMM_ZERO;
            imm_q       <= '0;
            rd_q        <= '0;
            rs1_addr    <= '0;
            rs2_addr    <= '0;
            alu_control <= '0;
            src1        <= '0;
            src2        <= '0;
            imm_val_r   <= '0;
            shamt       <= '0;
            rd_we       <= 1'b0;
            rd_addr     <= '0;
            rd_wdata    <= '0;
            br_valid    <= 1'b0;
            br_taken    <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            rd_we    <= 1'b0;
            br_valid <= 1'b0;
            br_taken <= 1'b0;
            illegal  <= 1'b0;
            case (state)
                S_IDLE: if (instr_valid) begin
                    rs1_addr    <= instr[19:15];
                    rs2_addr    <= instr[24:20];
                    rd_q        <= instr[11:7];
                    imm_q       <= instr[31:20];
                    code_q      <= dec_code;
                    br_q        <= dec_br;
                    imm_sel_q   <= dec_imm_sel;
                    illegal     <= dec_illegal;
                    instr_ready <= 1'b0;
                    state       <= S_DECODE;
                end
                S_DECODE: if (illegal) begin
                    instr_ready <= 1'b1;
                    state       <= S_IDLE;
                end else begin
                    alu_control <= code_q;
                    src1        <= swap ? rs2_data : rs1_data;
                    src2        <= swap ? rs1_data : rs2_data;
                    imm_val_r   <= imm_sel_q == IMM_SEXT ? XLEN'($signed(imm_q)) :
                                   imm_sel_q == IMM_ZEXT ? XLEN'(imm_q[4:0]) :
                                   imm_sel_q == IMM_RS1  ? rs1_data : '0;
                    shamt       <= imm_sel_q == IMM_RS1 ? imm_q[3:0] : '0;
                    state       <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    rd_we    <= !br_q && rd_q != '0;
                    rd_addr  <= rd_q;
                    rd_wdata <= alu_result;
                    br_valid <= br_q;
                    br_taken <= br_q & alu_result[0];
                    state    <= S_WB;
                end
                default: begin
                    alu_control <= '0;
                    src1        <= '0;
                    src2        <= '0;
                    imm_val_r   <= '0;
                    shamt       <= '0;
                    instr_ready <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: drives directed and random RV32I instructions through the issue controller,
// playing register file and ALU, and compares against an instruction-level reference model.
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_ready, rd_we, br_valid, br_taken, illegal;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] rs1_data, rs2_data, src1, src2, imm_val_r, alu_result, rd_wdata;
    logic [5:0]  alu_control;
    logic [3:0]  shamt;
    logic [31:0] rf [32];
    int          n_tests = 0;
    int          n_fail = 0;

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, B = 7'b1100011;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .alu_control(alu_control), .src1(src1), .src2(src2), .imm_val_r(imm_val_r), .shamt(shamt),
        .alu_result(alu_result), .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
        .br_valid(br_valid), .br_taken(br_taken), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];

    // ALU as seen by the controller: immediate ops use imm_val_r, slli is imm<<shamt, bge tests src2>=src1
    function automatic logic [31:0] alu_env(input logic [5:0] op, input logic [31:0] a, b, imm, input logic [3:0] sh);
        case (op)
            6'd1:  return a + b;
            6'd2:  return a - b;
            6'd3:  return a << b[4:0];
            6'd4:  return {31'b0, $signed(a) < $signed(b)};
            6'd6:  return a ^ b;
            6'd7:  return a >> b[4:0];
            6'd8:  return $signed(a) >>> b[4:0];
            6'd9:  return a | b;
            6'd10: return a & b;
            6'd11: return a + imm;
            6'd12: return imm << sh;
            6'd13: return {31'b0, $signed(a) < $signed(imm)};
            6'd15: return a ^ imm;
            6'd16: return a >> imm[4:0];
            6'd17: return a | imm;
            6'd18: return a & imm;
            6'd27: return {31'b0, a == b};
            6'd28: return {31'b0, a != b};
            6'd31: return {31'b0, $signed(b) >= $signed(a)};
            6'd32: return {31'b0, $signed(a) < $signed(b)};
            default: return 32'b0;
        endcase
    endfunction

    always_comb alu_result = alu_env(alu_control, src1, src2, imm_val_r, shamt);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    // Architectural view: what each instruction should produce from the register values
    function automatic void model(input logic [31:0] w, output bit ill, output logic [5:0] code,
                                  output logic [31:0] imm, output logic [3:0] sh, output bit br,
                                  output logic [31:0] res);
        logic [31:0] a, b, si;
        logic [2:0]  f3;
        logic [6:0]  f7;
        a = rf[w[19:15]];
        b = rf[w[24:20]];
        si = {{20{w[31]}}, w[31:20]};
        f3 = w[14:12];
        f7 = w[31:25];
        code = 0; imm = 0; sh = 0; br = 0; res = 0;
        case (w[6:0])
            R: if (f7 == 7'h00) begin
                case (f3)
                    3'd0: begin code = 6'd1;  res = a + b; end
                    3'd1: begin code = 6'd3;  res = a << b[4:0]; end
                    3'd2: begin code = 6'd4;  res = {31'b0, $signed(a) < $signed(b)}; end
                    3'd4: begin code = 6'd6;  res = a ^ b; end
                    3'd5: begin code = 6'd7;  res = a >> b[4:0]; end
                    3'd6: begin code = 6'd9;  res = a | b; end
                    3'd7: begin code = 6'd10; res = a & b; end
                    default: ;
                endcase
            end else if (f7 == 7'h20) begin
                if (f3 == 3'd0) begin code = 6'd2; res = a - b; end
                if (f3 == 3'd5) begin code = 6'd8; res = $signed(a) >>> b[4:0]; end
            end
            I: begin
                imm = si;
                case (f3)
                    3'd0: begin code = 6'd11; res = a + si; end
                    3'd1: if (f7 == 0) begin code = 6'd12; imm = a; sh = w[23:20]; res = a << w[23:20]; end
                    3'd2: begin code = 6'd13; res = {31'b0, $signed(a) < $signed(si)}; end
                    3'd4: begin code = 6'd15; res = a ^ si; end
                    3'd5: if (f7 == 0) begin code = 6'd16; imm = {27'b0, w[24:20]}; res = a >> w[24:20]; end
                    3'd6: begin code = 6'd17; res = a | si; end
                    3'd7: begin code = 6'd18; res = a & si; end
                    default: ;
                endcase
            end
            B: begin
                br = 1;
                case (f3)
                    3'd0: begin code = 6'd27; res = {31'b0, a == b}; end
                    3'd1: begin code = 6'd28; res = {31'b0, a != b}; end
                    3'd4: begin code = 6'd32; res = {31'b0, $signed(a) < $signed(b)}; end
                    3'd5: begin code = 6'd31; res = {31'b0, $signed(a) >= $signed(b)}; end
                    default: ;
                endcase
            end
            default: ;
        endcase
        ill = code == 0;
        if (ill) begin imm = 0; br = 0; end
    endfunction

    task automatic issue(input logic [31:0] w);
        bit ill, br, we;
        logic [5:0] code;
        logic [31:0] imm, res;
        logic [3:0] sh;
        model(w, ill, code, imm, sh, br, res);
        we = !ill && !br && w[11:7] != 0;
        @(negedge clk);
        check("ready_idle", instr_ready, 1);
        instr_valid = 1'b1;
        instr = w;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        instr = $urandom;
        @(negedge clk);
        check("illegal", illegal, ill);
        check("busy_decode", instr_ready, 0);
        check("ctl_decode", alu_control, 0);
        if (ill) begin
            @(negedge clk);
            check("ready_after_ill", instr_ready, 1);
            check("strobes_after_ill", {rd_we, br_valid, illegal}, 0);
            return;
        end
        @(negedge clk);
        check("alu_control", alu_control, code);
        check("imm_val_r", imm_val_r, imm);
        check("shamt", shamt, sh);
        check("strobes_exec", {rd_we, br_valid, illegal}, 0);
        @(negedge clk);
        check("rd_we", rd_we, we);
        if (we) begin
            check("rd_addr", rd_addr, w[11:7]);
            check("rd_wdata", rd_wdata, res);
        end
        check("br_valid", br_valid, br);
        if (br) check("br_taken", br_taken, res[0]);
        check("illegal_wb", illegal, 0);
        @(negedge clk);
        check("ready_next", instr_ready, 1);
        check("strobes_idle", {rd_we, br_valid, illegal}, 0);
        check("ctl_idle", alu_control, 0);
    endtask

    initial begin
        int acc [$];
        int nwe;
        logic [31:0] w;
        for (int i = 0; i < 32; i++) rf[i] = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", instr_ready, 1);
        check("rst_ctl", alu_control, 0);
        check("rst_ops", src1 | src2 | imm_val_r, 0);
        check("rst_outs", {shamt, rd_addr, rs1_addr, rs2_addr}, 0);
        check("rst_strobes", {rd_we, br_valid, br_taken, illegal}, 0);

        rf[1] = 5; rf[2] = 7;
        issue(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, R));
        issue(enc(7'h7f, 5'h1f, 5'd1, 3'd0, 5'd4, I));
        issue(enc(7'h00, 5'd3, 5'd1, 3'd1, 5'd5, I));
        issue(enc(7'h00, 5'd2, 5'd1, 3'd3, 5'd3, R));
        issue(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd0, R));
        rf[1] = 7; rf[2] = 5;
        issue(enc(7'h00, 5'd2, 5'd1, 3'd5, 5'd9, B));
        issue(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd9, B));
        issue(enc(7'h00, 5'd1, 5'd2, 3'd5, 5'd9, B));

        // back-to-back: valid held high must be accepted every 4th cycle
        rf[1] = 5; rf[2] = 7;
        @(negedge clk);
        instr_valid = 1'b1;
        instr = enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, R);
        nwe = 0;
        for (int i = 0; i < 12; i++) begin
            if (instr_ready) acc.push_back(i);
            if (rd_we) begin
                nwe++;
                check("b2b_wdata", rd_wdata, 12);
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        check("b2b_accepts", acc.size(), 3);
        check("b2b_writes", nwe, 3);
        for (int k = 1; k < acc.size(); k++) check("b2b_gap", acc[k] - acc[k-1], 4);

        // reset during EXECUTE drops the instruction
        @(negedge clk);
        instr_valid = 1'b1;
        instr = enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, R);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_exec_ctl", alu_control, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_ready", instr_ready, 1);
        check("abort_ctl", alu_control, 0);
        check("abort_ops", src1 | src2 | imm_val_r | rd_wdata, 0);
        for (int i = 0; i < 4; i++) begin
            check("abort_strobes", {rd_we, br_valid, illegal}, 0);
            @(negedge clk);
        end

        for (int i = 1; i < 32; i++) rf[i] = (i % 4 == 0) ? $urandom_range(0, 3) : $urandom;
        rf[9] = rf[8];
        for (int n = 0; n < 120; n++) begin
            int k;
            k = $urandom_range(0, 9);
            w = $urandom;
            w[6:0] = k < 4 ? R : k < 7 ? I : k < 9 ? B : 7'($urandom);
            if (w[6:0] != B && $urandom_range(0, 3) != 0) w[31:25] = $urandom_range(0, 1) ? 7'h00 : 7'h20;
            if (w[6:0] == B && $urandom_range(0, 2) == 0) begin w[19:15] = 5'd8; w[24:20] = 5'd9; end
            issue(w);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue controller that sits on the driving side of the processor's ALU. It accepts one 32-bit RV32I instruction through a valid/ready handshake, reads the register file, and decodes the instruction into the ALU's 6-bit operation code and operands. It then captures the ALU result and issues either a register write-back or a branch decision. It is the sole source of `alu_control`, `src1`, `src2`, `imm_val_r` and `shamt`.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `RF_AW`, 5: register-address width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr_valid` in 1: an instruction is offered.
- `instr_ready` out 1: controller can accept; high only in IDLE.
- `instr` in 32: instruction word; sampled when `instr_valid & instr_ready`.
- `rs1_addr`, `rs2_addr` out 5: register-file read addresses.
- `rs1_data`, `rs2_data` in 32: register-file read data; combinational from the address.
- `alu_control` out 6: ALU operation code.
- `src1`, `src2` out 32: ALU operands.
- `imm_val_r` out 32: ALU immediate operand.
- `shamt` out 4: ALU shift amount.
- `alu_result` in 32: ALU combinational result.
- `rd_we` out 1: one-cycle register write strobe.
- `rd_addr` out 5: destination register address.
- `rd_wdata` out 32: destination register write data.
- `br_valid` out 1: one-cycle branch-decision strobe.
- `br_taken` out 1: branch condition result; meaningful only with `br_valid`.
- `illegal` out 1: one-cycle strobe for an unsupported instruction.

## Operation
- The FSM has four states: IDLE, DECODE, EXECUTE and WB.
- IDLE → DECODE on handshake. The instruction is latched, and `rs1_addr`/`rs2_addr` are driven from bits [19:15]/[24:20].
- DECODE, legal instruction → EXECUTE. `rs1_data`/`rs2_data` are registered into `src1`/`src2`, and the operation code is registered.
- DECODE, illegal instruction → IDLE. `illegal` pulses in this cycle.
- EXECUTE → WB. `alu_control`, the operands and the immediate are held stable for the whole cycle. `alu_result` is registered at the end of the cycle.
- WB → IDLE, with one of two outcomes:
  - ALU/immediate class: `rd_we=1`, `rd_addr=instr[11:7]`, `rd_wdata` = the captured result. If `rd_addr==0`, `rd_we` is suppressed.
  - Branch class: `br_valid=1`, `br_taken=result[0]`, and `rd_we=0`.
- Decode map, format funct3 → code:
  - R-type (opcode 0110011), with funct7=0000000 unless noted: add 000→000001, sub 000 with funct7=0100000→000010, sll 001→000011, slt 010→000100, xor 100→000110, srl 101→000111, sra 101 with funct7=0100000→001000, or 110→001001, and 111→001010.
  - I-type (opcode 0010011): addi 000→001011, slli 001→001100, slti 010→001101, xori 100→001111, srli 101→010000, ori 110→010001, andi 111→010010.
  - Branch (opcode 1100011): beq 000→011011, bne 001→011100, blt 100→100000, bge 101→011111. For bge, `src1`/`src2` are swapped so that the ALU's src2≥src1 test yields rs1≥rs2.
  - Illegal: every other opcode/funct3/funct7 combination, including sltu, bltu, bgeu and srai.
- Immediate rules:
  - I-type, default: `imm_val_r` = sign-extended instr[31:20].
  - srli: `imm_val_r` = zero-extended instr[24:20].
  - slli: `imm_val_r` = rs1 data and `shamt` = instr[23:20]. This makes the ALU's imm<<shamt produce rs1<<shamt.
  - R-type and branch: `imm_val_r` = 0.
- Outside EXECUTE and WB, `alu_control`, `src1`, `src2`, `imm_val_r` and `shamt` are 0. Code 000000 is idle to the ALU.

## Timing
- Handshake in cycle 0; DECODE in cycle 1; EXECUTE in cycle 2; WB strobe in cycle 3; `instr_ready` high again in cycle 4.
- Throughput is one instruction per 4 cycles. An illegal instruction takes 2 cycles.
- Reset value of every output is 0, except `instr_ready`, which is 1 in the cycle after reset is released (state IDLE).
- `rst` asserted in any state forces IDLE on the next edge. The in-flight instruction is dropped, and no `rd_we`, `br_valid` or `illegal` strobe is emitted.
- While `instr_ready=0`, `instr_valid` and `instr` are ignored. The producer must hold them until the handshake occurs.
- `rd_we`, `br_valid` and `illegal` are mutually exclusive and each lasts exactly one cycle.

## Structure
- A shared package `alu_pkg` holds:
  - the six-bit ALU code localparams (ALU_ADD … ALU_BLT);
  - the opcode constants OP_R, OP_I and OP_BR;
  - the FSM state encoding.
  - The ALU itself is to be migrated to these constants.
- One sub-module, `alu_decode`, is combinational: instruction in; code, class, illegal flag and immediate select out. The FSM and operand registers stay in `alu_issue_ctrl`.

## Test plan
- add x3,x1,x2 with x1=5, x2=7 → `alu_control`=000001 in cycle 2; `rd_we`=1, `rd_addr`=3, `rd_wdata`=12 in cycle 3.
- addi x4,x1,-1 with x1=5 → `imm_val_r`=0xFFFFFFFF, code 001011; `rd_wdata`=4. slli x5,x1,3 → `rd_wdata`=40.
- bge x1,x2 with x1=7, x2=5 → `br_valid`=1, `br_taken`=1. beq with 7,5 → `br_taken`=0. Neither asserts `rd_we`.
- sltu (R-type funct3=011) → `illegal` pulse in cycle 1; `instr_ready` high in cycle 2; no `rd_we`.
- add x0,x1,x2 → WB completes with `rd_we`=0. Back-to-back `instr_valid` held high → accepts exactly every 4th cycle.
- `rst` pulsed during EXECUTE → next cycle IDLE, all outputs 0, and no strobe for the aborted instruction.
